// File: rtl/seg_nibble_counter_if.sv
// seg_nibble_counter_if
//   Bundles the control inputs and display/status outputs of seg_nibble_counter.
//   clk and rst_n stay as plain ports on the modules that use this interface.
//
//   btn_run   raw run/stop push-button, active-high
//   btn_step  raw single-step push-button, active-high
//   up_dn     1 = count up, 0 = count down
//   clr       synchronous clear, level-sensitive
//   a,b,c,d   count nibble to the seven-segment decoder (a = MSB, d = LSB)
//   running   high while the counter is in RUN
//   tc        one-cycle terminal-count pulse on a wrap
//
//   master: the side driving buttons/controls (board logic or testbench).
//   slave:  the counter itself.
interface seg_nibble_counter_if;
    logic btn_run;
    logic btn_step;
    logic up_dn;
    logic clr;
    logic a;
    logic b;
    logic c;
    logic d;
    logic running;
    logic tc;

    modport master (
        output btn_run, btn_step, up_dn, clr,
        input  a, b, c, d, running, tc
    );

    modport slave (
        input  btn_run, btn_step, up_dn, clr,
        output a, b, c, d, running, tc
    );
endinterface

// File: rtl/seg_nibble_counter.sv
// seg_nibble_counter
//   Modulo-(MAX_VAL+1) up/down counter driving a 4-input seven-segment decoder.
//   Counts at a prescaled rate while running; run/stop and single-step come
//   from two debounced push-buttons. Emits a one-cycle tc pulse on each wrap
//   so a second digit can be cascaded.
//
//   Ports:
//     clk    system clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    seg_nibble_counter_if.slave (buttons, up_dn, clr in;
//            a..d, running, tc out)
//
//   Parameters:
//     TICK_DIV    clock cycles per count tick while running (>= 2)
//     DEB_CYCLES  cycles a synchronized button level must differ from the
//                 accepted level before it is taken (>= 1)
//     MAX_VAL     highest count value (1..15)
module seg_nibble_counter #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned DEB_CYCLES = 500_000,
    parameter int unsigned MAX_VAL    = 9
) (
    input logic                 clk,
    input logic                 rst_n,
    seg_nibble_counter_if.slave bus
);

    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned PW = $clog2(TICK_DIV);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    MAX_C      = 4'(MAX_VAL);

    // Button index 0 = run, 1 = step.
    localparam int unsigned BtnRun  = 0;
    localparam int unsigned BtnStep = 1;

    typedef enum logic [0:0] {StStop, StRun} state_e;

    // ------------------------------------------------------------------
    // Synchronizers and debouncers
    // ------------------------------------------------------------------
    logic [1:0]    raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    level_q;
    logic [1:0]    level_d;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] deb_cnt_d [2];
    logic [1:0]    press;

    assign raw = {bus.btn_step, bus.btn_run};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // The counter tracks consecutive cycles of disagreement; any agreement
    // (i.e. a bounce back) restarts it. The press pulse fires in the cycle
    // the new high level is accepted, so the FSM and counter act on the
    // same edge that updates level_q.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            level_d[i]   = level_q[i];
            deb_cnt_d[i] = '0;
            press[i]     = 1'b0;
            if (sync2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    level_d[i] = sync2_q[i];
                    press[i]   = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Run/stop FSM
    // ------------------------------------------------------------------
    state_e state_q;
    state_e state_d;
    logic   running;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StStop;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStop: if (press[BtnRun]) state_d = StRun;
            StRun:  if (press[BtnRun]) state_d = StStop;
            default: state_d = StStop;
        endcase
    end

    always_comb begin
        running = (state_q == StRun);
    end

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;

    assign tick = running && (presc_q == PRESC_LAST);

    // Held at zero outside RUN, which also gives the clear-on-entry.
    always_comb begin
        presc_d = presc_q + PW'(1);
        if (bus.clr || !running || tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Counter and terminal count
    // ------------------------------------------------------------------
    logic [3:0] count_q;
    logic [3:0] count_d;
    logic       tc_q;
    logic       tc_d;
    logic       count_ev;

    // Step presses only count while stopped.
    assign count_ev = running ? tick : press[BtnStep];

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.clr) begin
            count_d = '0;
        end else if (count_ev) begin
            if (bus.up_dn) begin
                // >= also recovers an out-of-range value back to 0.
                if (count_q >= MAX_C) begin
                    count_d = '0;
                    tc_d    = (count_q == MAX_C);
                end else begin
                    count_d = count_q + 4'd1;
                end
            end else begin
                if ((count_q == 4'd0) || (count_q > MAX_C)) begin
                    count_d = MAX_C;
                    tc_d    = (count_q == 4'd0);
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.a       = count_q[3];
    assign bus.b       = count_q[2];
    assign bus.c       = count_q[1];
    assign bus.d       = count_q[0];
    assign bus.running = running;
    assign bus.tc      = tc_q;

endmodule

// File: tb/tb_seg_nibble_counter.sv
// tb_seg_nibble_counter
//   Directed bench for seg_nibble_counter with TICK_DIV=4, DEB_CYCLES=3,
//   MAX_VAL=9. Inputs change 1 time unit after a rising edge; outputs are
//   sampled at that same point, after the edge has settled.
module tb_seg_nibble_counter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks    = 0;
    int failures  = 0;
    int e         = 0;
    int tc_seen   = 0;
    int bad       = 0;

    always #5 clk = ~clk;

    seg_nibble_counter_if bus ();

    seg_nibble_counter #(
        .TICK_DIV   (4),
        .DEB_CYCLES (3),
        .MAX_VAL    (9)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [3:0] nib();
        return {bus.a, bus.b, bus.c, bus.d};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
        if (bus.tc === 1'b1) tc_seen++;
    endtask

    initial begin
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        bus.up_dn    = 1'b1;
        bus.clr      = 1'b0;
        rst_n        = 1'b0;

        // Reset release
        repeat (20) step();
        check("rst_nib", 32'(nib()), 0);
        check("rst_running", 32'(bus.running), 0);
        check("rst_tc", 32'(bus.tc), 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            step();
            if (nib() !== 4'd0 || bus.running !== 1'b0 || bus.tc !== 1'b0) bad++;
        end
        check("rst_stable_bad_cycles", 32'(bad), 0);

        // Run, count up through a wrap, then clr on a wrapping tick.
        // Run press accepted at edge 5; count k appears at edge 5+4k.
        e = 0;
        tc_seen = 0;
        bus.btn_run = 1'b1;
        while (e < 113) begin
            step();
            if (e == 10) bus.btn_run = 1'b0;
            if (e == 4) check("run_pre_edge4", 32'(bus.running), 0);
            if (e == 5) check("run_at_edge5", 32'(bus.running), 1);
            if (e == 8) check("cnt_before_first_tick", 32'(nib()), 0);
            if (e >= 9 && e <= 45 && ((e - 5) % 4) == 0)
                check("run_cnt", 32'(nib()), 32'(((e - 5) / 4) % 10));
            if (e == 44) check("cnt_9_before_wrap", 32'(nib()), 9);
            if (e == 45) check("tc_on_wrap", 32'(bus.tc), 1);
            if (e == 46) check("tc_one_cycle", 32'(bus.tc), 0);
            if (e == 84) begin
                check("cnt_9_before_clr", 32'(nib()), 9);
                bus.clr = 1'b1;
            end
            if (e == 85) begin
                check("clr_cnt", 32'(nib()), 0);
                check("clr_no_tc", 32'(bus.tc), 0);
                check("clr_running", 32'(bus.running), 1);
                bus.clr = 1'b0;
            end
            if (e == 88) check("clr_hold_0", 32'(nib()), 0);
            if (e == 89) check("clr_next_tick", 32'(nib()), 1);
            if (e == 113) check("cnt_7_before_rst", 32'(nib()), 7);
        end
        check("run_tc_pulses", 32'(tc_seen), 1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_nib", 32'(nib()), 0);
        check("async_rst_running", 32'(bus.running), 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Down count from 0 via two step presses in STOP
        bus.up_dn = 1'b0;
        e = 0;
        tc_seen = 0;
        bus.btn_step = 1'b1;
        while (e < 40) begin
            step();
            if (e == 10) bus.btn_step = 1'b0;
            if (e == 20) bus.btn_step = 1'b1;
            if (e == 30) bus.btn_step = 1'b0;
            if (e == 4) check("dn_before_press", 32'(nib()), 0);
            if (e == 5) begin
                check("dn_wrap_to_9", 32'(nib()), 9);
                check("dn_tc", 32'(bus.tc), 1);
            end
            if (e == 6) check("dn_tc_one_cycle", 32'(bus.tc), 0);
            if (e == 24) check("dn_hold_9", 32'(nib()), 9);
            if (e == 25) check("dn_to_8", 32'(nib()), 8);
        end
        check("dn_tc_pulses", 32'(tc_seen), 1);
        check("dn_still_stopped", 32'(bus.running), 0);

        // Bounce rejection: 2-cycle toggles never last 3 cycles
        bus.up_dn = 1'b1;
        tc_seen = 0;
        for (int i = 0; i < 20; i++) begin
            bus.btn_step = ((i % 4) < 2);
            step();
        end
        bus.btn_step = 1'b0;
        repeat (5) step();
        check("bounce_no_count", 32'(nib()), 8);
        bus.btn_step = 1'b1;
        repeat (10) step();
        bus.btn_step = 1'b0;
        repeat (10) step();
        check("bounce_one_inc", 32'(nib()), 9);
        check("bounce_no_tc", 32'(tc_seen), 0);

        // Run and step pressed together in STOP: enter RUN, step applied once
        e = 0;
        tc_seen = 0;
        bus.btn_run  = 1'b1;
        bus.btn_step = 1'b1;
        while (e < 12) begin
            step();
            if (e == 10) begin
                bus.btn_run  = 1'b0;
                bus.btn_step = 1'b0;
            end
            if (e == 5) begin
                check("both_cnt_wrap", 32'(nib()), 0);
                check("both_running", 32'(bus.running), 1);
                check("both_tc", 32'(bus.tc), 1);
            end
            if (e == 9) check("both_first_tick", 32'(nib()), 1);
        end
        check("both_tc_pulses", 32'(tc_seen), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
